// File: rtl/sm4_key_sched_engine.sv
// SM4 key schedule: ROUNDS_PER_CYCLE rounds per clock into a 32x32 round-key bank; optional zeroize via SM4_KEY_ZEROIZE_EN.
// Latency: 32/ROUNDS_PER_CYCLE cycles from key acceptance to done_out; read port is 1 cycle.
// Backpressure: key_ready_out is low while expanding, so the requester must hold the key.

module sm4_key_t (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);
    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic [31:0] w_b;

    assign w_b = {SBOX[i_x[31:24]], SBOX[i_x[23:16]], SBOX[i_x[15:8]], SBOX[i_x[7:0]]};
    // Key-schedule linear layer: B ^ (B<<<13) ^ (B<<<23)
    assign o_y = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};
endmodule

module sm4_key_sched_engine #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         decrypt_in,
    input  logic         key_valid_in,
    output logic         key_ready_out,
    output logic         busy_out,
    output logic         done_out,
    output logic         keys_valid_out,
    input  logic [4:0]   rd_addr_in,
    output logic [31:0]  rd_data_out
`ifdef SM4_KEY_ZEROIZE_EN
    ,
    input  logic         zeroize_in
`endif
);
    localparam int EXP_CYCLES = 32 / ROUNDS_PER_CYCLE;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_rpc
        $fatal(1, "ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [31:0] FK0 = 32'ha3b1bac6;
    localparam logic [31:0] FK1 = 32'h56aa3350;
    localparam logic [31:0] FK2 = 32'h677d9197;
    localparam logic [31:0] FK3 = 32'hb27022dc;

    state_t      r_state;
    logic [31:0] r_k [4];
    logic [31:0] r_bank [32];
    logic [4:0]  r_rcnt;
    logic        r_mode;
    logic [31:0] r_rd_data;
    logic        r_key_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_keys_valid;

    logic [ROUNDS_PER_CYCLE:0][3:0][31:0] w_win;
    logic [31:0] w_ck [ROUNDS_PER_CYCLE];
    logic [31:0] w_t  [ROUNDS_PER_CYCLE];
    logic [31:0] w_rk [ROUNDS_PER_CYCLE];
    logic [4:0]  w_rd_idx;
    logic        w_zero;

`ifdef SM4_KEY_ZEROIZE_EN
    assign w_zero = zeroize_in;
`else
    assign w_zero = 1'b0;
`endif

    // CK byte j of round i is ((4i+j)*7) mod 256, MSB first; 8-bit arithmetic gives the mod for free
    function automatic logic [31:0] ck_gen(input logic [4:0] i);
        logic [31:0] c;
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[31-8*j -: 8] = ({1'b0, i, 2'b00} + 8'(j)) * 8'd7;
        end
        return c;
    endfunction

    assign w_win[0][0] = r_k[0];
    assign w_win[0][1] = r_k[1];
    assign w_win[0][2] = r_k[2];
    assign w_win[0][3] = r_k[3];

    for (genvar u = 0; u < ROUNDS_PER_CYCLE; u++) begin : g_round
        assign w_ck[u] = ck_gen(r_rcnt + 5'(u));
        sm4_key_t u_t (
            .i_x (w_win[u][1] ^ w_win[u][2] ^ w_win[u][3] ^ w_ck[u]),
            .o_y (w_t[u])
        );
        assign w_rk[u]        = w_win[u][0] ^ w_t[u];
        assign w_win[u+1][0]  = w_win[u][1];
        assign w_win[u+1][1]  = w_win[u][2];
        assign w_win[u+1][2]  = w_win[u][3];
        assign w_win[u+1][3]  = w_rk[u];
    end

    assign w_rd_idx = r_mode ? (5'd31 - rd_addr_in) : rd_addr_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rcnt       <= '0;
            r_mode       <= 1'b0;
            r_rd_data    <= '0;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int j = 0; j < 4; j++) r_k[j] <= '0;
            for (int a = 0; a < 32; a++) r_bank[a] <= '0;
        end else if (w_zero) begin
            r_state      <= IDLE;
            r_rcnt       <= '0;
            r_mode       <= 1'b0;
            r_rd_data    <= '0;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int j = 0; j < 4; j++) r_k[j] <= '0;
            for (int a = 0; a < 32; a++) r_bank[a] <= '0;
        end else begin
            // Reads see the bank before this edge's writes
            r_rd_data <= r_bank[w_rd_idx];
            r_done    <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (key_valid_in) begin
                        r_k[0]       <= key_in[127:96] ^ FK0;
                        r_k[1]       <= key_in[95:64]  ^ FK1;
                        r_k[2]       <= key_in[63:32]  ^ FK2;
                        r_k[3]       <= key_in[31:0]   ^ FK3;
                        r_mode       <= decrypt_in;
                        r_rcnt       <= '0;
                        r_state      <= EXPAND;
                        r_key_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_keys_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    for (int u = 0; u < ROUNDS_PER_CYCLE; u++) begin
                        r_bank[r_rcnt + 5'(u)] <= w_rk[u];
                    end
                    for (int j = 0; j < 4; j++) r_k[j] <= w_win[ROUNDS_PER_CYCLE][j];
                    r_rcnt <= r_rcnt + 5'(ROUNDS_PER_CYCLE);
                    if (r_rcnt == 5'(32 - ROUNDS_PER_CYCLE)) begin
                        r_state      <= DONE;
                        r_key_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_keys_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_key_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready_out  = r_key_ready;
    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign keys_valid_out = r_keys_valid;
    assign rd_data_out    = r_rd_data;

    logic w_unused;
    assign w_unused = ^EXP_CYCLES;
endmodule

// File: tb/tb_sm4_key_sched_engine.sv
// Bench for sm4_key_sched_engine: five instances (R=1,2,4,8,32) against a
// behavioural key-schedule model.
module tb_sm4_key_sched_engine;
    localparam int N = 5;
    localparam logic [127:0] KEY_STD = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [7:0] SBOX_T [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [127:0]      key_in;
    logic              decrypt_in;
    logic [N-1:0]      kv;
    logic [4:0]        rd_addr;
    logic [N-1:0]      ready, busy, done, kvalid;
    logic [N-1:0][31:0] rd_data;
`ifdef SM4_KEY_ZEROIZE_EN
    logic              zeroize_in;
`endif

    sm4_key_sched_engine #(.ROUNDS_PER_CYCLE(1)) u_dut0 (
`ifdef SM4_KEY_ZEROIZE_EN
        .zeroize_in     (zeroize_in),
`endif
        .clk            (clk),
        .rst_n          (rst_n),
        .key_in         (key_in),
        .decrypt_in     (decrypt_in),
        .key_valid_in   (kv[0]),
        .key_ready_out  (ready[0]),
        .busy_out       (busy[0]),
        .done_out       (done[0]),
        .keys_valid_out (kvalid[0]),
        .rd_addr_in     (rd_addr),
        .rd_data_out    (rd_data[0])
    );

    for (genvar g = 1; g < N; g++) begin : g_dut
        sm4_key_sched_engine #(.ROUNDS_PER_CYCLE((g == 4) ? 32 : (1 << g))) u_dut (
`ifdef SM4_KEY_ZEROIZE_EN
            .zeroize_in     (zeroize_in),
`endif
            .clk            (clk),
            .rst_n          (rst_n),
            .key_in         (key_in),
            .decrypt_in     (decrypt_in),
            .key_valid_in   (kv[g]),
            .key_ready_out  (ready[g]),
            .busy_out       (busy[g]),
            .done_out       (done[g]),
            .keys_valid_out (kvalid[g]),
            .rd_addr_in     (rd_addr),
            .rd_data_out    (rd_data[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_rk [32];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int rpc(input int g);
        return (g == 4) ? 32 : (1 << g);
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tprime(input logic [31:0] x);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = SBOX_T[x[8*j +: 8]];
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    function automatic logic [31:0] ck(input int i);
        logic [31:0] c;
        for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return c;
    endfunction

    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        k[0] = mk[127:96] ^ 32'ha3b1bac6;
        k[1] = mk[95:64]  ^ 32'h56aa3350;
        k[2] = mk[63:32]  ^ 32'h677d9197;
        k[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            k[i+4]    = k[i] ^ tprime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(i));
            exp_rk[i] = k[i+4];
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k, input logic d, input logic [N-1:0] mask);
        key_in     = k;
        decrypt_in = d;
        kv         = mask;
        tick;
        kv         = '0;
    endtask

    // Called at the sample point right after the acceptance edge (cycle 0)
    task automatic wait_done(input logic [N-1:0] mask, input bit probe_ck, input string tag);
        int lat [N];
        int bc  [N];
        int dc  [N];
        for (int g = 0; g < N; g++) begin
            lat[g] = 0;
            bc[g]  = int'(busy[g]);
            dc[g]  = 0;
        end
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (probe_ck && c == 31) check($sformatf("%s_ck31", tag), u_dut0.w_ck[0], 32'h646b7279);
            for (int g = 0; g < N; g++) begin
                bc[g] += int'(busy[g]);
                if (done[g]) begin
                    dc[g]++;
                    if (lat[g] == 0) lat[g] = c;
                end
            end
        end
        for (int g = 0; g < N; g++) begin
            if (mask[g]) begin
                check($sformatf("%s_done_lat_R%0d", tag, rpc(g)), 32'(lat[g]), 32'(32 / rpc(g)));
                check($sformatf("%s_busy_cnt_R%0d", tag, rpc(g)), 32'(bc[g]), 32'(32 / rpc(g)));
                check($sformatf("%s_done_pulses_R%0d", tag, rpc(g)), 32'(dc[g]), 32'd1);
            end
        end
        check($sformatf("%s_keys_valid", tag), 32'(kvalid & mask), 32'(mask));
    endtask

    task automatic read_all(input logic d, input logic [N-1:0] mask, input string tag);
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            tick;
            for (int g = 0; g < N; g++) begin
                if (mask[g]) check($sformatf("%s_R%0d_a%0d", tag, rpc(g), a), rd_data[g],
                                   exp_rk[d ? 31 - a : a]);
            end
        end
    endtask

    initial begin
        logic [127:0] key2;
        logic [31:0]  k1_rk0;
        logic [127:0] rk;
        logic         rd;
        int           lat;

        rst_n = 1'b1; key_in = '0; decrypt_in = 1'b0; kv = '0; rd_addr = '0;
`ifdef SM4_KEY_ZEROIZE_EN
        zeroize_in = 1'b0;
`endif
        #2 rst_n = 1'b0;
        tick; tick;
        check("rst_ready", 32'(ready), 32'h1f);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_kvalid", 32'(kvalid), 32'h0);
        for (int g = 0; g < N; g++) check($sformatf("rst_rd_R%0d", rpc(g)), rd_data[g], 32'h0);
        rst_n = 1'b1;
        tick;

        // Standard vector, encrypt order
        model_expand(KEY_STD);
        load(KEY_STD, 1'b0, 5'h1f);
        check("ck0", u_dut0.w_ck[0], 32'h00070e15);
        check("busy_after_accept", 32'(busy), 32'h1f);
        check("kvalid_after_accept", 32'(kvalid), 32'h0);
        wait_done(5'h1f, 1'b1, "std_enc");
        rd_addr = 5'd0;
        tick;
        for (int g = 0; g < N; g++) check($sformatf("enc_a0_R%0d", rpc(g)), rd_data[g], 32'hf12186f9);
        rd_addr = 5'd31;
        #1;
        check("enc_rd_registered", rd_data[0], 32'hf12186f9);
        tick;
        for (int g = 0; g < N; g++) check($sformatf("enc_a31_R%0d", rpc(g)), rd_data[g], 32'h9124a012);
        read_all(1'b0, 5'h1f, "enc");

        // Standard vector, decrypt order
        load(KEY_STD, 1'b1, 5'h1f);
        wait_done(5'h1f, 1'b0, "std_dec");
        rd_addr = 5'd0;
        tick;
        check("dec_a0", rd_data[0], 32'h9124a012);
        rd_addr = 5'd31;
        tick;
        check("dec_a31", rd_data[0], 32'hf12186f9);
        read_all(1'b1, 5'h1f, "dec");

        // Random keys and order
        for (int t = 0; t < 3; t++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rd = 1'($urandom_range(0, 1));
            model_expand(rk);
            load(rk, rd, 5'h1f);
            wait_done(5'h1f, 1'b0, $sformatf("rnd%0d", t));
            read_all(rd, 5'h1f, $sformatf("rnd%0d", t));
        end

        // Key held valid through EXPAND on the R=1 instance: second key waits for DONE
        model_expand(KEY_STD);
        k1_rk0 = exp_rk[0];
        key2 = {$urandom, $urandom, $urandom, $urandom};
        rd_addr = 5'd0;
        key_in = KEY_STD; decrypt_in = 1'b0; kv = 5'b00001;
        tick;
        key_in = key2;
        repeat (32) tick;
        check("hold_done", 32'(done[0]), 32'd1);
        check("hold_kvalid", 32'(kvalid[0]), 32'd1);
        check("hold_first_rk0", rd_data[0], k1_rk0);
        tick;
        kv = '0;
        check("hold_kvalid_drop", 32'(kvalid[0]), 32'd0);
        check("hold_busy_again", 32'(busy[0]), 32'd1);
        check("hold_rd_before_write", rd_data[0], k1_rk0);
        tick;
        check("hold_rd_collision_old", rd_data[0], k1_rk0);
        model_expand(key2);
        tick;
        check("hold_rd_new", rd_data[0], exp_rk[0]);
        lat = 0;
        for (int c = 36; c <= 80 && lat == 0; c++) begin
            tick;
            if (done[0]) lat = c;
        end
        check("hold_second_done_cycle", 32'(lat), 32'd65);
        check("hold_second_kvalid", 32'(kvalid[0]), 32'd1);
        read_all(1'b0, 5'b00001, "hold_key2");

        // Reset in the middle of expansion
        model_expand(KEY_STD);
        load(KEY_STD, 1'b0, 5'h1f);
        repeat (10) tick;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_kvalid", 32'(kvalid), 32'h0);
        check("midrst_ready", 32'(ready), 32'h1f);
        check("midrst_rd", rd_data[0], 32'h0);
        #2 rst_n = 1'b1;
        tick;
        check("postrst_kvalid", 32'(kvalid), 32'h0);
        load(KEY_STD, 1'b0, 5'h1f);
        wait_done(5'h1f, 1'b0, "postrst");
        read_all(1'b0, 5'h1f, "postrst");

`ifdef SM4_KEY_ZEROIZE_EN
        zeroize_in = 1'b1;
        tick;
        zeroize_in = 1'b0;
        check("zero_kvalid", 32'(kvalid), 32'h0);
        check("zero_rd", rd_data[0], 32'h0);
        for (int a = 0; a < 32; a++) exp_rk[a] = '0;
        read_all(1'b0, 5'h1f, "zero_bank");
        key_in = KEY_STD; kv = 5'h1f; zeroize_in = 1'b1;
        tick;
        kv = '0; zeroize_in = 1'b0;
        check("zero_vs_load_busy", 32'(busy), 32'h0);
        check("zero_vs_load_ready", 32'(ready), 32'h1f);
        tick;
        check("zero_vs_load_idle", 32'(busy | kvalid | done), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sm4_key_sched_engine.md
Name: sm4_key_sched_engine

Overview:
- Sequential SM4 key-schedule engine. Accepts a 128-bit user key over a valid/ready handshake.
- Iterates the key-expansion round ROUNDS_PER_CYCLE times per clock and stores all 32 round keys in an internal 32x32 register bank.
- Serves the round keys through a registered read port, in encrypt order or decrypt (reversed) order.
- Sits between the key-load interface and the round datapath, replacing per-round combinational key expansion.

Parameters:
- ROUNDS_PER_CYCLE, 1, unrolled key-expansion rounds per clock. Legal values: 1, 2, 4, 8, 16, 32. Any other value is a fatal elaboration error.
- EXP_CYCLES, 32/ROUNDS_PER_CYCLE, derived localparam (not overridable): number of expansion cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_in  in  128  user key MK0..MK3, MK0 in [127:96]
- decrypt_in  in  1  order select, sampled at key acceptance: 1 = reversed read order
- key_valid_in  in  1  key load request
- key_ready_out  out  1  engine can accept a key
- busy_out  out  1  expansion in progress
- done_out  out  1  one-cycle pulse: all 32 keys written
- keys_valid_out  out  1  round-key bank complete and readable
- rd_addr_in  in  5  round index 0..31
- rd_data_out  out  32  round key, registered

Behaviour:
- Reset: async on rst_n low. State <= IDLE; key_ready_out = 1; busy_out, done_out, keys_valid_out, rd_data_out = 0. Key bank, working registers, round counter and mode flag all clear to 0.
- Reset asserted mid-expansion aborts immediately. No partial keys are ever flagged valid.
- FSM states: IDLE, EXPAND, DONE.
- key_ready_out = 1 in IDLE and DONE, 0 in EXPAND.
- Key acceptance: on the edge where key_valid_in && key_ready_out:
  - K0..K3 <= MKi ^ FKi, with FK = a3b1bac6, 56aa3350, 677d9197, b27022dc.
  - mode <= decrypt_in; rcnt <= 0; state <= EXPAND.
  - keys_valid_out falls on the same edge.
- EXPAND, per cycle: compute ROUNDS_PER_CYCLE chained rounds combinationally.
  - Round i: rk_i = K_i ^ T'(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i).
  - T' = S-box tau followed by L'(B) = B ^ (B<<<13) ^ (B<<<23); instantiate the existing key transform block once per unrolled round.
  - CK_i is generated arithmetically, not stored in a ROM: byte j = ((4i+j)*7) mod 256, j=0 is the MSB.
  - Write rk_i into bank[i] for i = rcnt..rcnt+R-1. Shift the working window; rcnt += R.
  - rcnt is 5 bits, modulo 32. Wrap to 0 coincides with the final write.
- Leaving EXPAND: after exactly EXP_CYCLES EXPAND edges, state <= DONE, done_out = 1 for one cycle, keys_valid_out = 1.
  - done_out rises EXP_CYCLES cycles after the acceptance edge (32 cycles for R=1, 1 cycle for R=32).
- busy_out = 1 exactly while in EXPAND.
- Read port: rd_data_out <= bank[mode ? 31-rd_addr_in : rd_addr_in] every cycle. One-cycle latency, all states.
  - Data read while keys_valid_out = 0 is don't-care for consumers, but must be deterministic: the current bank contents.
- Reload in DONE is allowed. A new key restarts EXPAND and overwrites the bank progressively.
- key_valid_in in EXPAND is ignored (ready low). The requester must hold the key.
- A read and a bank write to the same entry on the same edge returns the old value.

Optional Feature:
- Macro SM4_KEY_ZEROIZE_EN.
- With the macro defined:
  - Adds input port zeroize_in (1 bit).
  - A synchronous zeroize_in = 1 clears the bank, K registers, rcnt, mode and rd_data_out to 0. State <= IDLE, keys_valid_out <= 0, done_out <= 0, in any state.
  - zeroize_in takes priority over a simultaneous key acceptance.
- Without the macro: no port. Key material persists until overwritten or until rst_n.

Test Plan:
- R=1, key 0123456789abcdeffedcba9876543210, decrypt_in=0 -> done_out pulses exactly 32 cycles after acceptance; rd_addr 0 -> f12186f9; rd_addr 31 -> 9124a012; busy_out high for 32 cycles.
- Same key, decrypt_in=1 -> rd_addr 0 -> 9124a012; rd_addr 31 -> f12186f9; each read data appears one cycle after its address.
- Sweep R=2,4,8,32 with the same key -> identical 32-entry bank; done_out latency 16, 8, 4, 1 cycles; CK_0 = 00070e15, CK_31 = 646b7279 observed internally.
- key_valid_in held high during EXPAND with a second key -> ignored; first key's results are correct; the second key is accepted in DONE, and keys_valid_out drops on that edge and returns after EXP_CYCLES.
- rst_n pulsed low at expansion cycle 10 (R=1) -> all outputs 0 immediately; key_ready_out = 1; a fresh load afterwards produces the correct bank.
- SM4_KEY_ZEROIZE_EN defined, zeroize_in in DONE -> next cycle keys_valid_out = 0 and every address reads 00000000; zeroize_in coincident with key_valid_in -> load rejected, state IDLE.
